fifo_packer: RTL and testbench
==============================

FIFO_PACKER -- requirements
Module: fifo_packer

Interface
REQ-001 Parameter DEPTH, default 4, depth of the upstream fifo being drained.
REQ-002 Parameter WIDTH, default 2, bit width of one fifo word.
REQ-003 Parameter PACK, default 4, number of fifo words per packed output word.
REQ-004 Parameter CW, default 3, occupancy counter width, SHALL hold 0..DEPTH.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 fifo_push  input  1  copy of the push strobe driven into the upstream fifo.
REQ-008 fifo_full  input  1  full flag of the upstream fifo.
REQ-009 fifo_out  input  WIDTH  head word of the upstream fifo, valid while occ>0.
REQ-010 fifo_pop  output  1  pop strobe to the upstream fifo.
REQ-011 pk_data  output  WIDTH*PACK  packed word.
REQ-012 pk_valid  output  1  pk_data valid.
REQ-013 pk_ready  input  1  downstream accepts pk_data.
REQ-014 occ  output  CW  mirrored fifo occupancy.

Function
REQ-015 Accepted push = fifo_push && !fifo_full; occ SHALL +1 on accepted push without pop, -1 on pop without accepted push, hold on both or neither.
REQ-016 occ SHALL never exceed DEPTH nor go below 0; pop SHALL never be driven with occ==0.
REQ-017 FSM states FILL and HOLD; an index counter idx (0..PACK-1) tracks words collected.
REQ-018 In FILL, fifo_pop SHALL be combinationally 1 iff occ>0; fifo_out SHALL be captured into pk_data[idx*WIDTH +: WIDTH] on that edge (first word at LSBs).
REQ-019 In FILL, a pop with idx<PACK-1 SHALL increment idx; a pop with idx==PACK-1 SHALL clear idx and move to HOLD.
REQ-020 In HOLD, pk_valid SHALL be 1 and fifo_pop SHALL be 0; pk_data SHALL be stable.
REQ-021 pk_valid SHALL rise the cycle after the PACK-th pop (latency 1 cycle).
REQ-022 In HOLD, pk_valid && pk_ready SHALL return the FSM to FILL next cycle; pk_ready SHALL be ignored in FILL.
REQ-023 Back-to-back packs SHALL incur exactly one non-popping cycle (the handshake cycle) between them.
REQ-024 Unused pk_data bits of a pack in progress SHALL retain old values; only a complete or flushed pack is meaningful.

Reset
REQ-025 On reset low, immediately: state=FILL, idx=0, occ=0, pk_data=0, pk_valid=0, fifo_pop=0.
REQ-026 Reset mid-pack or mid-HOLD SHALL discard the partial or pending pack; the upstream fifo SHALL be reset together with this block.

Configuration
REQ-027 Macro FIFO_PACKER_FLUSH_EN, when defined, SHALL add input port flush (1 bit).
REQ-028 With FIFO_PACKER_FLUSH_EN: flush in FILL with idx>0, or with a pop on the same edge, SHALL move to HOLD including any word popped that edge, zero the remaining upper slots, and clear idx.
REQ-029 With FIFO_PACKER_FLUSH_EN: flush with idx==0 and no pop, or flush in HOLD, SHALL be ignored.
REQ-030 Without FIFO_PACKER_FLUSH_EN, no flush port SHALL exist and packs close only at PACK words.

Verification
REQ-031 Reset, push 11,10,11,00 on 4 cycles, pk_ready=0 -> pk_valid=1 one cycle after 4th pop, pk_data=8'h3B, held until pk_ready.
REQ-032 Push 4 words while pk_valid=1 and pk_ready=0 -> occ reaches 4, fifo_full respected, no pop, occ never 5.
REQ-033 Continuous pushes with pk_ready=1 -> packs every 5 cycles, occ stays in 0..4, no word lost or duplicated.
REQ-034 Push and pop on same edge -> occ unchanged.
REQ-035 Reset low during HOLD with occ=3 -> pk_valid=0, occ=0, idx=0 immediately, without a clock edge.
REQ-036 FIFO_PACKER_FLUSH_EN: push 10,01 then flush -> pk_data=8'h06 with pk_valid the next cycle; flush at idx==0 -> no pk_valid.

Source files
------------

// File: rtl/fifo_packer.sv
// fifo_packer: drains an upstream fifo PACK words at a time into one wide
// word. A FILL/HOLD FSM pops one word per cycle while the mirrored
// occupancy is non-zero, then holds the packed word until it is accepted.
// Optional feature: define FIFO_PACKER_FLUSH_EN to add a 'flush' input
// that closes a partial pack early, zeroing the unused upper slots.
module fifo_packer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2,
  parameter int PACK  = 4,
  parameter int CW    = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fifo_push,
  input  logic                    fifo_full,
  input  logic [WIDTH-1:0]        fifo_out,
  output logic                    fifo_pop,
  output logic [WIDTH*PACK-1:0]   pk_data,
  output logic                    pk_valid,
  input  logic                    pk_ready,
  output logic [CW-1:0]           occ
`ifdef FIFO_PACKER_FLUSH_EN
  ,
  input  logic                    flush
`endif
);

  localparam int IW   = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int CNTW = IW + 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(PACK - 1);
  localparam logic [CW-1:0] OCC_MAX  = CW'(DEPTH);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [IW-1:0]           idx_r;
  logic [IW-1:0]           idx_nxt_s;
  logic [CW-1:0]           occ_r;
  logic [CW-1:0]           occ_nxt_s;
  logic [WIDTH*PACK-1:0]   pk_data_r;
  logic [WIDTH*PACK-1:0]   pk_data_nxt_s;
  logic                    fifo_pop_s;
  logic                    pk_valid_s;
  logic                    push_acc_s;
  logic                    flush_s;
  logic                    close_s;
  logic [CNTW-1:0]         fill_cnt_s;

`ifdef FIFO_PACKER_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  assign push_acc_s = fifo_push & ~fifo_full;

  // A pack closes on the PACK-th pop, or early on a flush that has data to close.
  assign close_s = (state_r == ST_FILL) &
                   ((fifo_pop_s & (idx_r == IDX_LAST)) |
                    (flush_s & (fifo_pop_s | (idx_r != '0))));

  // Number of valid slots once this edge's pop (if any) is captured.
  assign fill_cnt_s = {1'b0, idx_r} + {{(CNTW-1){1'b0}}, fifo_pop_s};

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_FILL;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: FILL until a pack closes, HOLD until it is accepted.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_FILL: begin
        if (close_s) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      ST_HOLD: begin
        if (pk_ready) begin
          state_nxt_s = ST_FILL;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: state_nxt_s = ST_FILL;
    endcase
  end

  // FSM outputs: pop whenever FILL sees data; valid throughout HOLD.
  always_comb begin
    fifo_pop_s = 1'b0;
    pk_valid_s = 1'b0;
    case (state_r)
      ST_FILL: begin
        fifo_pop_s = (occ_r != '0);
        pk_valid_s = 1'b0;
      end
      ST_HOLD: begin
        fifo_pop_s = 1'b0;
        pk_valid_s = 1'b1;
      end
      default: begin
        fifo_pop_s = 1'b0;
        pk_valid_s = 1'b0;
      end
    endcase
  end

  // Slot index: advance per pop, restart whenever a pack closes.
  always_comb begin
    idx_nxt_s = idx_r;
    if (close_s) begin
      idx_nxt_s = '0;
    end else if (fifo_pop_s) begin
      idx_nxt_s = idx_r + 1'b1;
    end else begin
      idx_nxt_s = idx_r;
    end
  end

  // Occupancy mirror: count accepted pushes against pops, clamped to 0..DEPTH.
  always_comb begin
    occ_nxt_s = occ_r;
    case ({push_acc_s, fifo_pop_s})
      2'b10: begin
        if (occ_r != OCC_MAX) begin
          occ_nxt_s = occ_r + 1'b1;
        end else begin
          occ_nxt_s = occ_r;
        end
      end
      2'b01: begin
        if (occ_r != '0) begin
          occ_nxt_s = occ_r - 1'b1;
        end else begin
          occ_nxt_s = occ_r;
        end
      end
      default: occ_nxt_s = occ_r;
    endcase
  end

  // Pack data: drop the popped word into its slot; a flush clears the unused upper slots.
  always_comb begin
    pk_data_nxt_s = pk_data_r;
    for (int i = 0; i < PACK; i++) begin
      if (fifo_pop_s && (idx_r == IW'(i))) begin
        pk_data_nxt_s[i*WIDTH +: WIDTH] = fifo_out;
      end else if (close_s && flush_s && (CNTW'(i) >= fill_cnt_s)) begin
        pk_data_nxt_s[i*WIDTH +: WIDTH] = '0;
      end else begin
        pk_data_nxt_s[i*WIDTH +: WIDTH] = pk_data_r[i*WIDTH +: WIDTH];
      end
    end
  end

  // Datapath registers; reset discards any partial or pending pack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_r     <= '0;
      occ_r     <= '0;
      pk_data_r <= '0;
    end else begin
      idx_r     <= idx_nxt_s;
      occ_r     <= occ_nxt_s;
      pk_data_r <= pk_data_nxt_s;
    end
  end

  assign fifo_pop = fifo_pop_s;
  assign pk_valid = pk_valid_s;
  assign pk_data  = pk_data_r;
  assign occ      = occ_r;

endmodule

// File: tb/tb_fifo_packer.sv
// Directed testbench for fifo_packer with a behavioural 4-deep upstream fifo.
// Define FIFO_PACKER_FLUSH_EN to also exercise the flush input.
module tb_fifo_packer;

  logic       clk;
  logic       reset;
  logic       fifo_push;
  logic       fifo_full;
  logic [1:0] fifo_out;
  logic       fifo_pop;
  logic [7:0] pk_data;
  logic       pk_valid;
  logic       pk_ready;
  logic [2:0] occ;
  logic [1:0] din;
`ifdef FIFO_PACKER_FLUSH_EN
  logic       flush;
`endif

  int checks = 0;
  int errors = 0;

  fifo_packer #(.DEPTH(4), .WIDTH(2), .PACK(4), .CW(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .fifo_push(fifo_push),
    .fifo_full(fifo_full),
    .fifo_out (fifo_out),
    .fifo_pop (fifo_pop),
    .pk_data  (pk_data),
    .pk_valid (pk_valid),
    .pk_ready (pk_ready),
    .occ      (occ)
`ifdef FIFO_PACKER_FLUSH_EN
    ,
    .flush    (flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream fifo model, reset together with the packer.
  logic [1:0] mem [0:3];
  logic [1:0] wp;
  logic [1:0] rp;
  logic [2:0] cnt;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp  <= 2'd0;
      rp  <= 2'd0;
      cnt <= 3'd0;
    end else begin
      if (fifo_push && !fifo_full) begin
        mem[wp] <= din;
        wp      <= wp + 2'd1;
      end
      if (fifo_pop) begin
        rp <= rp + 2'd1;
      end
      cnt <= cnt + 3'((fifo_push && !fifo_full) ? 1 : 0) - 3'(fifo_pop ? 1 : 0);
    end
  end

  assign fifo_out  = mem[rp];
  assign fifo_full = (cnt == 3'd4);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] w);
    fifo_push = 1'b1;
    din       = w;
    tick();
  endtask

  logic [1:0] expq [$];
  logic [7:0] exp_pk;
  int         last_c;
  int         npacks;

  initial begin
    reset     = 1'b0;
    fifo_push = 1'b0;
    din       = 2'd0;
    pk_ready  = 1'b0;
`ifdef FIFO_PACKER_FLUSH_EN
    flush     = 1'b0;
`endif
    #2;
    chk("rst_valid", 32'(pk_valid), 32'd0);
    chk("rst_occ",   32'(occ),      32'd0);
    chk("rst_pop",   32'(fifo_pop), 32'd0);
    chk("rst_data",  32'(pk_data),  32'd0);
    tick();
    tick();
    reset = 1'b1;

    // First pack: 11,10,11,00 -> 8'h3B one cycle after the 4th pop.
    push(2'b11);
    chk("p1_occ1", 32'(occ), 32'd1);
    chk("p1_pop1", 32'(fifo_pop), 32'd1);
    push(2'b10);
    chk("p1_occ_pushpop", 32'(occ), 32'd1);
    push(2'b11);
    chk("p1_occ_pushpop2", 32'(occ), 32'd1);
    push(2'b00);
    chk("p1_not_valid_yet", 32'(pk_valid), 32'd0);
    fifo_push = 1'b0;
    tick();
    chk("p1_valid", 32'(pk_valid), 32'd1);
    chk("p1_data",  32'(pk_data),  32'h3B);
    chk("p1_occ0",  32'(occ),      32'd0);
    tick();
    tick();
    chk("p1_hold_valid", 32'(pk_valid), 32'd1);
    chk("p1_hold_data",  32'(pk_data),  32'h3B);

    // Fill the upstream fifo while HOLD waits: occ saturates at 4, no pops.
    push(2'b01);
    chk("h_occ1", 32'(occ), 32'd1);
    chk("h_nopop", 32'(fifo_pop), 32'd0);
    push(2'b10);
    chk("h_occ2", 32'(occ), 32'd2);
    push(2'b11);
    chk("h_occ3", 32'(occ), 32'd3);
    push(2'b01);
    chk("h_occ4", 32'(occ), 32'd4);
    push(2'b10);
    chk("h_occ_full", 32'(occ), 32'd4);
    chk("h_nopop_full", 32'(fifo_pop), 32'd0);
    chk("h_data_stable", 32'(pk_data), 32'h3B);
    fifo_push = 1'b0;
    pk_ready  = 1'b1;
    tick();
    pk_ready  = 1'b0;
    chk("hs_valid_low", 32'(pk_valid), 32'd0);
    chk("hs_occ", 32'(occ), 32'd4);
    chk("hs_pop", 32'(fifo_pop), 32'd1);
    tick();
    tick();
    tick();
    chk("p2_not_valid_yet", 32'(pk_valid), 32'd0);
    tick();
    chk("p2_valid", 32'(pk_valid), 32'd1);
    chk("p2_data",  32'(pk_data),  32'h79);
    chk("p2_occ0",  32'(occ),      32'd0);

    // Continuous stream with pk_ready high: one pack every 5 cycles.
    pk_ready = 1'b1;
    tick();
    chk("s_hs_valid_low", 32'(pk_valid), 32'd0);
    fifo_push = 1'b1;
    last_c = -1;
    npacks = 0;
    for (int c = 0; c < 40; c++) begin
      din = 2'(c * 3 + 1);
      if (!fifo_full) expq.push_back(din);
      tick();
      chk("s_occ_range", 32'(occ <= 3'd4), 32'd1);
      chk("s_no_pop_empty", 32'(!(fifo_pop && (occ == 3'd0))), 32'd1);
      if (pk_valid) begin
        if (expq.size() < 4) begin
          chk("s_underflow", 32'(expq.size()), 32'd4);
        end else begin
          exp_pk = 8'd0;
          for (int k = 0; k < 4; k++) exp_pk[k*2 +: 2] = expq.pop_front();
          chk("s_pack_data", 32'(pk_data), 32'(exp_pk));
        end
        if (last_c >= 0) chk("s_pack_gap", 32'(c - last_c), 32'd5);
        last_c = c;
        npacks++;
      end
    end
    chk("s_pack_count", 32'(npacks >= 7), 32'd1);
    fifo_push = 1'b0;
    pk_ready  = 1'b0;

    // Asynchronous reset during HOLD with occ=3.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    push(2'b01);
    push(2'b10);
    push(2'b11);
    push(2'b00);
    fifo_push = 1'b0;
    tick();
    chk("r_valid", 32'(pk_valid), 32'd1);
    chk("r_data",  32'(pk_data),  32'h39);
    push(2'b01);
    push(2'b01);
    push(2'b01);
    fifo_push = 1'b0;
    chk("r_occ3", 32'(occ), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    chk("r_async_valid", 32'(pk_valid), 32'd0);
    chk("r_async_occ",   32'(occ),      32'd0);
    chk("r_async_pop",   32'(fifo_pop), 32'd0);
    chk("r_async_data",  32'(pk_data),  32'd0);
    tick();
    reset = 1'b1;

    // Fresh pack after reset: old pending pack must be gone.
    push(2'b11);
    push(2'b11);
    push(2'b11);
    push(2'b11);
    fifo_push = 1'b0;
    tick();
    chk("q_valid", 32'(pk_valid), 32'd1);
    chk("q_data",  32'(pk_data),  32'hFF);
    pk_ready = 1'b1;
    tick();
    pk_ready = 1'b0;
    chk("q_hs_valid_low", 32'(pk_valid), 32'd0);

`ifdef FIFO_PACKER_FLUSH_EN
    // Flush with nothing collected is ignored.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("f_idle_valid", 32'(pk_valid), 32'd0);
    // 10,01 then flush on the edge of the second pop -> 8'h06.
    push(2'b10);
    push(2'b01);
    fifo_push = 1'b0;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    chk("f_valid", 32'(pk_valid), 32'd1);
    chk("f_data",  32'(pk_data),  32'h06);
    chk("f_occ",   32'(occ),      32'd0);
    // Flush during HOLD is ignored.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("f_hold_valid", 32'(pk_valid), 32'd1);
    chk("f_hold_data",  32'(pk_data),  32'h06);
    pk_ready = 1'b1;
    tick();
    pk_ready = 1'b0;
    chk("f_hs_valid_low", 32'(pk_valid), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
